rsa_job_sequencer: RTL and testbench
====================================

Name: rsa_job_sequencer

Overview:
- Sequences one RSA `control` core (modular inverter followed by modular exponentiation) for a stream of encrypt/decrypt jobs.
- Takes jobs from a valid/ready request port and drives the core's `p`/`q`/`msg_in`/`encrypt_decrypt`.
- Pulses `reset_inverter` and `reset_mod_exp` in order and returns `msg_out` on a valid/ready response port.
- Caches the key: the inverter phase is skipped when `p`/`q` match the previous successful job. A watchdog turns a hung core into an error response.

Parameters:
- WIDTH, 128, width of `p`/`q`; message width is 2*WIDTH.
- TIMEOUT, 1048576, max cycles per phase waiting for finish.
- TO_W, 21, timeout counter width (must hold TIMEOUT).

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  job offered
- req_ready  out  1  sequencer can accept job
- req_p  in  WIDTH  prime p
- req_q  in  WIDTH  prime q
- req_encrypt_decrypt  in  1  direction passed to core
- req_msg  in  2*WIDTH  message
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_msg  out  2*WIDTH  core result, 0 on error
- rsp_error  out  1  job aborted by watchdog
- rsp_key_reused  out  1  inverter phase was skipped for this job
- core_p  out  WIDTH  to core p
- core_q  out  WIDTH  to core q
- core_encrypt_decrypt  out  1  to core
- core_msg_in  out  2*WIDTH  to core
- core_reset_inverter  out  1  one-cycle start pulse
- core_reset_mod_exp  out  1  one-cycle start pulse
- core_inverter_finish  in  1  from core
- core_mod_exp_finish  in  1  from core
- core_msg_out  in  2*WIDTH  from core
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, key_valid=0.
  - All outputs 0 except req_ready=1.
  - Core operand registers cleared to 0.
- States: IDLE, INV_START, INV_WAIT, EXP_START, EXP_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_p/req_q/req_encrypt_decrypt/req_msg into the core_* registers; they stay stable until the next accept.
  - If key_valid and req_p==key_p and req_q==key_q, go to EXP_START and set reused=1. Otherwise go to INV_START and set reused=0.
- INV_START / EXP_START:
  - Exactly one cycle with core_reset_inverter / core_reset_mod_exp = 1. The pulse is never longer than one cycle.
  - Timeout counter cleared.
  - Next state is INV_WAIT / EXP_WAIT.
- INV_WAIT / EXP_WAIT:
  - The first cycle is blanking: finish is ignored, because the core may still show the previous finish.
  - From the second cycle, finish=1 advances the state: INV_WAIT→EXP_START, EXP_WAIT→RESP.
  - On EXP_WAIT exit, capture rsp_msg=core_msg_out, rsp_error=0, rsp_key_reused=reused.
  - On INV_WAIT exit, set key_p/key_q to the latched values and key_valid=1.
  - Counter increments every WAIT cycle. If it reaches TIMEOUT-1 without finish: go to RESP with rsp_msg=0, rsp_error=1, key_valid=0.
  - Minimum job latency, accept→rsp_valid:
    - fresh key: 1+1+2+1+2 = 7 cycles when finish is already high at the first sampled cycle;
    - reused key: 4 cycles.
- RESP:
  - rsp_valid=1; rsp_msg/rsp_error/rsp_key_reused held stable until rsp_valid&&rsp_ready. Then go to IDLE and clear rsp_valid.
  - req_ready=0 here, so no new job is accepted in the handshake cycle; the earliest next accept is the following cycle.
- Only one job is in flight at a time; no buffering.
- Finish inputs are ignored outside WAIT states.
- Key comparison is a full WIDTH equality on both p and q; swapped p/q counts as a miss.
- reset_n asserted mid-job aborts immediately. No response is produced and key_valid=0.

Test Plan:
- Bench core model: inverter_finish rises 5 cycles after the reset_inverter pulse, mod_exp_finish rises 7 cycles after the reset_mod_exp pulse, both drop on their reset; msg_out = msg_in XOR 256'h5A.
- Fresh key:
  - Stimulus: p=8475698667747010771, q=11297384090418420749, msg=256'h2b00000000000000000000, enc=0, rsp_ready=1.
  - Required: exactly one reset_inverter pulse, then one reset_mod_exp pulse; rsp_msg=256'h2b0000000000000000005A, rsp_error=0, rsp_key_reused=0.
- Reused key: same p/q, msg=256'hc600, enc=1 → no reset_inverter pulse; rsp_msg=256'hc65A, rsp_key_reused=1; core_encrypt_decrypt=1 throughout.
- Swapped key: p=11297384090418420749, q=8475698667747010771 → inverter phase runs, rsp_key_reused=0.
- Stale finish: model holds mod_exp_finish=1 from the previous job during the blanking cycle → sequencer must not leave EXP_WAIT until the model's new finish.
- Timeout: TIMEOUT=16 and the model never asserts inverter_finish.
  - Required: rsp_valid after 16 INV_WAIT cycles with rsp_error=1 and rsp_msg=0.
  - The next job with the same p/q must run the inverter phase.
- Back-pressure and reset:
  - rsp_ready=0 for 10 cycles → rsp_valid and rsp_msg stable, req_ready=0.
  - reset_n pulsed low during EXP_WAIT → outputs at reset values the same cycle, req_ready=1, and the next identical job is not key-reused.

Source files
------------

// File: rtl/rsa_job_sequencer.sv
// Job sequencer for one RSA control core: runs the inverter then mod-exp phase per job,
// skips the inverter when the key matches the last good one, and aborts hung phases.
module rsa_job_sequencer #(
    parameter int WIDTH   = 128,
    parameter int TIMEOUT = 1048576,
    parameter int TO_W    = 21
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_p,
    input  logic [WIDTH-1:0]   req_q,
    input  logic               req_encrypt_decrypt,
    input  logic [2*WIDTH-1:0] req_msg,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_msg,
    output logic               rsp_error,
    output logic               rsp_key_reused,
    output logic [WIDTH-1:0]   core_p,
    output logic [WIDTH-1:0]   core_q,
    output logic               core_encrypt_decrypt,
    output logic [2*WIDTH-1:0] core_msg_in,
    output logic               core_reset_inverter,
    output logic               core_reset_mod_exp,
    input  logic               core_inverter_finish,
    input  logic               core_mod_exp_finish,
    input  logic [2*WIDTH-1:0] core_msg_out,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE, INV_START, INV_WAIT, EXP_START, EXP_WAIT, RESP
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   core_p_q, core_p_d;
    logic [WIDTH-1:0]   core_q_q, core_q_d;
    logic               core_ed_q, core_ed_d;
    logic [2*WIDTH-1:0] core_msg_q, core_msg_d;
    logic [WIDTH-1:0]   key_p_q, key_p_d;
    logic [WIDTH-1:0]   key_q_q, key_q_d;
    logic               key_valid_q, key_valid_d;
    logic               reused_q, reused_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] rsp_msg_q, rsp_msg_d;
    logic               rsp_error_q, rsp_error_d;
    logic               rsp_reused_q, rsp_reused_d;

    logic blank;
    logic timed_out;

    // A zero count marks the first WAIT cycle, where a finish left over from the previous run is ignored.
    assign blank     = (cnt_q == '0);
    assign timed_out = (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            core_p_q     <= '0;
            core_q_q     <= '0;
            core_ed_q    <= 1'b0;
            core_msg_q   <= '0;
            key_p_q      <= '0;
            key_q_q      <= '0;
            key_valid_q  <= 1'b0;
            reused_q     <= 1'b0;
            cnt_q        <= '0;
            rsp_msg_q    <= '0;
            rsp_error_q  <= 1'b0;
            rsp_reused_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_p_q     <= core_p_d;
            core_q_q     <= core_q_d;
            core_ed_q    <= core_ed_d;
            core_msg_q   <= core_msg_d;
            key_p_q      <= key_p_d;
            key_q_q      <= key_q_d;
            key_valid_q  <= key_valid_d;
            reused_q     <= reused_d;
            cnt_q        <= cnt_d;
            rsp_msg_q    <= rsp_msg_d;
            rsp_error_q  <= rsp_error_d;
            rsp_reused_q <= rsp_reused_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        core_p_d     = core_p_q;
        core_q_d     = core_q_q;
        core_ed_d    = core_ed_q;
        core_msg_d   = core_msg_q;
        key_p_d      = key_p_q;
        key_q_d      = key_q_q;
        key_valid_d  = key_valid_q;
        reused_d     = reused_q;
        cnt_d        = cnt_q;
        rsp_msg_d    = rsp_msg_q;
        rsp_error_d  = rsp_error_q;
        rsp_reused_d = rsp_reused_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    core_p_d   = req_p;
                    core_q_d   = req_q;
                    core_ed_d  = req_encrypt_decrypt;
                    core_msg_d = req_msg;
                    if (key_valid_q && (req_p == key_p_q) && (req_q == key_q_q)) begin
                        state_d  = EXP_START;
                        reused_d = 1'b1;
                    end else begin
                        state_d  = INV_START;
                        reused_d = 1'b0;
                    end
                end
            end
            INV_START: begin
                cnt_d   = '0;
                state_d = INV_WAIT;
            end
            INV_WAIT: begin
                if (!blank && core_inverter_finish) begin
                    state_d     = EXP_START;
                    key_p_d     = core_p_q;
                    key_q_d     = core_q_q;
                    key_valid_d = 1'b1;
                end else if (timed_out) begin
                    state_d      = RESP;
                    rsp_msg_d    = '0;
                    rsp_error_d  = 1'b1;
                    rsp_reused_d = reused_q;
                    key_valid_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXP_START: begin
                cnt_d   = '0;
                state_d = EXP_WAIT;
            end
            EXP_WAIT: begin
                if (!blank && core_mod_exp_finish) begin
                    state_d      = RESP;
                    rsp_msg_d    = core_msg_out;
                    rsp_error_d  = 1'b0;
                    rsp_reused_d = reused_q;
                end else if (timed_out) begin
                    state_d      = RESP;
                    rsp_msg_d    = '0;
                    rsp_error_d  = 1'b1;
                    rsp_reused_d = reused_q;
                    key_valid_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready            = (state_q == IDLE);
    assign busy                 = (state_q != IDLE);
    assign rsp_valid            = (state_q == RESP);
    assign core_reset_inverter  = (state_q == INV_START);
    assign core_reset_mod_exp   = (state_q == EXP_START);
    assign rsp_msg              = rsp_msg_q;
    assign rsp_error            = rsp_error_q;
    assign rsp_key_reused       = rsp_reused_q;
    assign core_p               = core_p_q;
    assign core_q               = core_q_q;
    assign core_encrypt_decrypt = core_ed_q;
    assign core_msg_in          = core_msg_q;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Directed bench for rsa_job_sequencer with a small behavioural core model
// (inverter done 5 cycles after its pulse, mod-exp 7 cycles, msg_out = msg_in ^ 'h5A).
module tb_rsa_job_sequencer;

    localparam int WIDTH = 128;
    localparam int MW    = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_p = '0;
    logic [WIDTH-1:0] req_q = '0;
    logic             req_encrypt_decrypt = 1'b0;
    logic [MW-1:0]    req_msg = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [MW-1:0]    rsp_msg;
    logic             rsp_error;
    logic             rsp_key_reused;
    logic [WIDTH-1:0] core_p;
    logic [WIDTH-1:0] core_q;
    logic             core_encrypt_decrypt;
    logic [MW-1:0]    core_msg_in;
    logic             core_reset_inverter;
    logic             core_reset_mod_exp;
    logic             core_inverter_finish;
    logic             core_mod_exp_finish;
    logic [MW-1:0]    core_msg_out;
    logic             busy;

    int errors = 0;
    int checks = 0;

    rsa_job_sequencer #(.WIDTH(WIDTH), .TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_p(req_p), .req_q(req_q),
        .req_encrypt_decrypt(req_encrypt_decrypt), .req_msg(req_msg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_msg(rsp_msg), .rsp_error(rsp_error), .rsp_key_reused(rsp_key_reused),
        .core_p(core_p), .core_q(core_q),
        .core_encrypt_decrypt(core_encrypt_decrypt), .core_msg_in(core_msg_in),
        .core_reset_inverter(core_reset_inverter), .core_reset_mod_exp(core_reset_mod_exp),
        .core_inverter_finish(core_inverter_finish), .core_mod_exp_finish(core_mod_exp_finish),
        .core_msg_out(core_msg_out), .busy(busy)
    );

    always #5 clk = ~clk;

    logic invFin = 1'b0, expFin = 1'b0;
    logic invRun = 1'b0, expRun = 1'b0, expDropPending = 1'b0;
    logic invHang = 1'b0, staleExp = 1'b0;
    int   invCnt = 0, expCnt = 0;

    // staleExp keeps the old mod-exp finish high for one extra cycle after the new start pulse.
    always @(posedge clk) begin
        if (core_reset_inverter) begin
            invFin <= 1'b0;
            invCnt <= 0;
            invRun <= !invHang;
        end else if (invRun) begin
            invCnt <= invCnt + 1;
            if (invCnt == 4) begin
                invFin <= 1'b1;
                invRun <= 1'b0;
            end
        end
        if (core_reset_mod_exp) begin
            if (staleExp) expDropPending <= 1'b1;
            else          expFin <= 1'b0;
            expCnt <= 0;
            expRun <= 1'b1;
        end else begin
            if (expDropPending) begin
                expFin         <= 1'b0;
                expDropPending <= 1'b0;
            end
            if (expRun) begin
                expCnt <= expCnt + 1;
                if (expCnt == 6) begin
                    expFin <= 1'b1;
                    expRun <= 1'b0;
                end
            end
        end
    end

    assign core_inverter_finish = invFin;
    assign core_mod_exp_finish  = expFin;
    assign core_msg_out         = core_msg_in ^ 256'h5A;

    int invPulseTotal = 0, expPulseTotal = 0;
    always @(negedge clk) begin
        if (core_reset_inverter) invPulseTotal <= invPulseTotal + 1;
        if (core_reset_mod_exp)  expPulseTotal <= expPulseTotal + 1;
    end

    task automatic check(input string tag, input logic [MW-1:0] observed, input logic [MW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q,
                                 input logic enc, input logic [MW-1:0] msg);
        int guard;
        @(negedge clk);
        req_p = p;
        req_q = q;
        req_encrypt_decrypt = enc;
        req_msg = msg;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic waitRsp(output int lat);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input string tag, input int lat, input int expLat,
                               input int invP, input int expInvP, input int expP, input int expExpP,
                               input logic [MW-1:0] msg, input logic err, input logic reused);
        check({tag, "_valid"},   rsp_valid, 1);
        check({tag, "_latency"}, lat, expLat);
        check({tag, "_invpulse"}, invP, expInvP);
        check({tag, "_exppulse"}, expP, expExpP);
        check({tag, "_msg"},     rsp_msg, msg);
        check({tag, "_error"},   rsp_error, err);
        check({tag, "_reused"},  rsp_key_reused, reused);
    endtask

    task automatic consumeRsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, inv0, exp0;
        logic stable;
        logic [MW-1:0] held;
        logic [WIDTH-1:0] pA, pB, pT, qT;
        pA = 128'd8475698667747010771;
        pB = 128'd11297384090418420749;
        pT = 128'd3;
        qT = 128'd5;

        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_core_msg", core_msg_in, 0);
        check("reset_rsp_msg", rsp_msg, 0);
        reset_n = 1'b1;

        inv0 = invPulseTotal; exp0 = expPulseTotal;
        applyStimulus(pA, pB, 1'b0, 256'h2b00000000000000000000);
        waitRsp(lat);
        checkOutput("fresh", lat, 16, invPulseTotal - inv0, 1, expPulseTotal - exp0, 1,
                    256'h2b0000000000000000005A, 1'b0, 1'b0);
        check("fresh_core_p", core_p, pA);
        check("fresh_core_q", core_q, pB);
        consumeRsp();

        inv0 = invPulseTotal; exp0 = expPulseTotal;
        applyStimulus(pA, pB, 1'b1, 256'hc600);
        check("reuse_enc", core_encrypt_decrypt, 1);
        waitRsp(lat);
        checkOutput("reuse", lat, 9, invPulseTotal - inv0, 0, expPulseTotal - exp0, 1,
                    256'hc65A, 1'b0, 1'b1);
        check("reuse_enc_end", core_encrypt_decrypt, 1);
        consumeRsp();

        inv0 = invPulseTotal; exp0 = expPulseTotal;
        applyStimulus(pB, pA, 1'b0, 256'h1234);
        waitRsp(lat);
        checkOutput("swap", lat, 16, invPulseTotal - inv0, 1, expPulseTotal - exp0, 1,
                    256'h126E, 1'b0, 1'b0);
        consumeRsp();

        staleExp = 1'b1;
        inv0 = invPulseTotal; exp0 = expPulseTotal;
        applyStimulus(pB, pA, 1'b0, 256'hF0);
        waitRsp(lat);
        checkOutput("stale", lat, 9, invPulseTotal - inv0, 0, expPulseTotal - exp0, 1,
                    256'hAA, 1'b0, 1'b1);
        consumeRsp();
        staleExp = 1'b0;

        invHang = 1'b1;
        inv0 = invPulseTotal; exp0 = expPulseTotal;
        applyStimulus(pT, qT, 1'b0, 256'h77);
        waitRsp(lat);
        checkOutput("timeout", lat, 17, invPulseTotal - inv0, 1, expPulseTotal - exp0, 0,
                    256'h0, 1'b1, 1'b0);
        consumeRsp();
        invHang = 1'b0;

        inv0 = invPulseTotal; exp0 = expPulseTotal;
        applyStimulus(pT, qT, 1'b0, 256'h77);
        waitRsp(lat);
        checkOutput("after_to", lat, 16, invPulseTotal - inv0, 1, expPulseTotal - exp0, 1,
                    256'h2D, 1'b0, 1'b0);
        consumeRsp();

        rsp_ready = 1'b0;
        inv0 = invPulseTotal; exp0 = expPulseTotal;
        applyStimulus(pT, qT, 1'b1, 256'h5A00);
        waitRsp(lat);
        checkOutput("bp", lat, 9, invPulseTotal - inv0, 0, expPulseTotal - exp0, 1,
                    256'h5A5A, 1'b0, 1'b1);
        held = rsp_msg;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_msg !== held || req_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        consumeRsp();
        check("bp_released_valid", rsp_valid, 0);
        check("bp_released_ready", req_ready, 1);

        applyStimulus(pT, qT, 1'b0, 256'h99);
        @(posedge clk);
        @(negedge clk);
        check("midjob_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_pulse", core_reset_mod_exp, 0);
        check("rst_core_msg", core_msg_in, 0);
        @(negedge clk);
        reset_n = 1'b1;

        inv0 = invPulseTotal; exp0 = expPulseTotal;
        applyStimulus(pT, qT, 1'b0, 256'h99);
        waitRsp(lat);
        checkOutput("post_rst", lat, 16, invPulseTotal - inv0, 1, expPulseTotal - exp0, 1,
                    256'hC3, 1'b0, 1'b0);
        consumeRsp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
